ni_tx_local: RTL and testbench
==============================

// Module: ni_tx_local
// PURPOSE
//  Synchronous network-interface transmitter for the local input port (DIR=4) of an SDM router input buffer.
//  Takes header and data words from a clocked IP core over valid/ready and emits one frame per header.
//  Each frame is a head flit, the data flits, then an end-of-frame token, all 1-of-4 encoded.
//  Drives the sub-channel wires o0..o3 and the eof wire o4 using the 4-phase return-to-zero handshake on oa.
// PARAMETERS
//  DW    16  data-path width in bits; must be even
//  SCN   DW/2  number of 1-of-4 digits per flit (derived)
//  SYNC  2   flops in the oa synchronizer; minimum 2
// PORTS
//  clk         in   1     clock
//  rst_n       in   1     synchronous reset, active low
//  hdr_valid   in   1     header request
//  hdr_ready   out  1     header accepted when hdr_valid&hdr_ready
//  dst_x       in   4     target x: digit0=dst_x[1:0], digit1=dst_x[3:2]
//  dst_y       in   4     target y: digit2=dst_y[1:0], digit3=dst_y[3:2]
//  hdr_usr     in   DW-8  user header bits for digits 4..SCN-1
//  data_valid  in   1     data word request
//  data_ready  out  1     data word accepted when data_valid&data_ready
//  data        in   DW    payload word
//  data_last   in   1     marks the final word of the frame
//  o0..o3      out  SCN   1-of-4 rails; digit k value v raises o<v>[k]
//  o4          out  1     end-of-frame token wire
//  oa          in   1     asynchronous 4-phase ack from router (ia of input buffer)
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is synchronous and active-low.
//  - Reset values: o0..o4=0, hdr_ready=0, data_ready=0, FSM=RSTW.
//  - Output registers: o0..o4 come directly from flops, so they are glitch-free.
//    All rails of a token update on the same edge.
//  - Ack synchronizer: oa passes through SYNC flops; oa_s is the last stage.
//  - Encoding: digit k carries word bits [2k+1:2k].
//    Head digits 0-3 carry x and y; digits 4.. carry hdr_usr[2(k-4)+1:2(k-4)].
//    The EOF token sets o4=1 with all of o0..o3 at 0.
//  - FSM states: RSTW, IDLE, SEND, RTZ.
//    RSTW: wait for oa_s==0, then go to IDLE. This covers reset while the router still holds ack.
//    IDLE: hdr_ready=1 only when oa_s==0.
//      On header handshake, load the head token into the output regs at the next edge. Set kind=HEAD. Go to SEND.
//    SEND: hold the token until oa_s==1. Then clear o0..o4 at the next edge. Go to RTZ.
//    RTZ: wait for oa_s==0, then pick the next token:
//      - kind HEAD or BODY, frame not done: data_ready=1 for the RTZ-exit cycle only.
//        On handshake, load the body token and go to SEND. Record data_last.
//        With no data_valid, stay in RTZ with all outputs 0.
//      - last body sent: load the EOF token and go to SEND.
//      - kind EOF: go to IDLE. The frame is complete.
//  - Handshake rules: hdr_ready and data_ready are never both 1.
//    Neither is ever 1 while any output rail is 1.
//  - Frame length: every frame carries at least one data word.
//    data_last on the first word gives head, 1 body, EOF.
//  - Throughput: a token is never changed while oa_s==1. A new token is never driven before oa_s==0.
//    Minimum period is 2*SYNC+2 cycles per token for an instantaneous ack.
//  - Back-pressure: the router may stall oa indefinitely. The outputs hold their values, with no timeout.
//  - Reset mid-operation: outputs drop to 0 on the next edge regardless of oa.
//    The partial frame is abandoned. RSTW blocks new traffic until the ack is released.
//  - Unknown oa, or oa rising while outputs are 0, is a protocol violation. It is ignored in RTZ and IDLE.
// CONFIGURATION
//  NI_TX_FRMCNT_EN defined: adds output frm_cnt [15:0].
//    - Increments on EOF ack (SEND->RTZ with kind=EOF) and wraps 16'hFFFF->0.
//    - Cleared by rst_n.
//  NI_TX_FRMCNT_EN undefined: no port and no counter logic.
// TESTING
//  1 Reset with oa=1 held 10 cycles -> outputs 0, hdr_ready=0. Release oa -> hdr_ready=1 SYNC+1 cycles later.
//  2 dst_x=5, dst_y=10, hdr_usr=0, DW=16 -> head o0=8'hF0, o1=8'h03, o2=8'h0C, o3=8'h00, o4=0.
//  3 data=16'hE4E4, data_last=1 -> body o0=8'h11, o1=8'h22, o2=8'h44, o3=8'h88. Then EOF o4=1 with rails 0, then IDLE.
//  4 3-word frame with a zero-delay ack model -> exactly 5 tokens, each separated by all-zero spacers.
//    Token period equals 2*SYNC+2 cycles.
//  5 Assert rst_n=0 while body token is in SEND with oa=1 -> outputs 0 next edge.
//    No new header is accepted until oa falls.
//  6 NI_TX_FRMCNT_EN: preload 65535 frames, or force the count -> frm_cnt wraps to 0 on the next frame.
//    Without the macro, the frm_cnt port is absent.

Source files
------------

// File: rtl/ni_tx_local.sv
// ni_tx_local: 1-of-4 RTZ network-interface transmitter for the local router port.
// Optional frame counter output frm_cnt is built when NI_TX_FRMCNT_EN is defined.
module ni_tx_local #(
    parameter int DW   = 16,
    parameter int SCN  = DW / 2,
    parameter int SYNC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           hdr_valid,
    output logic           hdr_ready,
    input  logic [3:0]     dst_x,
    input  logic [3:0]     dst_y,
    input  logic [DW-9:0]  hdr_usr,
    input  logic           data_valid,
    output logic           data_ready,
    input  logic [DW-1:0]  data,
    input  logic           data_last,
    output logic [SCN-1:0] o0,
    output logic [SCN-1:0] o1,
    output logic [SCN-1:0] o2,
    output logic [SCN-1:0] o3,
    output logic           o4,
`ifdef NI_TX_FRMCNT_EN
    output logic [15:0]    frm_cnt,
`endif
    input  logic           oa
);

    typedef enum logic [1:0] {
        RSTW,
        IDLE,
        SEND,
        RTZ
    } state_e;

    typedef enum logic [1:0] {
        K_HEAD,
        K_BODY,
        K_EOF
    } kind_e;

    state_e         state_q;
    kind_e          kind_q;
    logic           last_q;
    logic [SCN-1:0] o0_q;
    logic [SCN-1:0] o1_q;
    logic [SCN-1:0] o2_q;
    logic [SCN-1:0] o3_q;
    logic           o4_q;
    logic [SYNC-1:0] sync_q;
    logic           oa_s;

    logic [4*SCN-1:0] head_tok;
    logic [4*SCN-1:0] body_tok;

    // Each 2-bit digit k raises exactly one rail bit k; rails packed {o3,o2,o1,o0}.
    function automatic logic [4*SCN-1:0] enc_1of4(input logic [DW-1:0] w);
        logic [4*SCN-1:0] r;
        r = '0;
        for (int k = 0; k < SCN; k++) begin
            case (w[2*k +: 2])
                2'd0:    r[0*SCN + k] = 1'b1;
                2'd1:    r[1*SCN + k] = 1'b1;
                2'd2:    r[2*SCN + k] = 1'b1;
                default: r[3*SCN + k] = 1'b1;
            endcase
        end
        return r;
    endfunction

    assign head_tok = enc_1of4({hdr_usr, dst_y, dst_x});
    assign body_tok = enc_1of4(data);

    // Ack synchronizer; left unreset so a held ack stays visible through reset.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC-2:0], oa};
    end

    assign oa_s = sync_q[SYNC-1];

    // Ready flags decode registered state only; outputs are all-zero whenever
    // either one is raised.
    assign hdr_ready  = rst_n && (state_q == IDLE) && !oa_s;
    assign data_ready = rst_n && (state_q == RTZ) && !oa_s
                        && (kind_q != K_EOF) && !last_q;

    // Token sequencer: head, bodies, EOF, each followed by a return-to-zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RSTW;
            kind_q  <= K_HEAD;
            last_q  <= 1'b0;
            o0_q    <= '0;
            o1_q    <= '0;
            o2_q    <= '0;
            o3_q    <= '0;
            o4_q    <= 1'b0;
        end else begin
            unique case (state_q)
                RSTW: begin
                    if (!oa_s) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (hdr_valid && hdr_ready) begin
                        o0_q    <= head_tok[0*SCN +: SCN];
                        o1_q    <= head_tok[1*SCN +: SCN];
                        o2_q    <= head_tok[2*SCN +: SCN];
                        o3_q    <= head_tok[3*SCN +: SCN];
                        o4_q    <= 1'b0;
                        kind_q  <= K_HEAD;
                        last_q  <= 1'b0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (oa_s) begin
                        o0_q    <= '0;
                        o1_q    <= '0;
                        o2_q    <= '0;
                        o3_q    <= '0;
                        o4_q    <= 1'b0;
                        state_q <= RTZ;
                    end
                end
                RTZ: begin
                    if (!oa_s) begin
                        if (kind_q == K_EOF) begin
                            state_q <= IDLE;
                        end else if (last_q) begin
                            o4_q    <= 1'b1;
                            kind_q  <= K_EOF;
                            state_q <= SEND;
                        end else if (data_valid && data_ready) begin
                            o0_q    <= body_tok[0*SCN +: SCN];
                            o1_q    <= body_tok[1*SCN +: SCN];
                            o2_q    <= body_tok[2*SCN +: SCN];
                            o3_q    <= body_tok[3*SCN +: SCN];
                            o4_q    <= 1'b0;
                            kind_q  <= K_BODY;
                            last_q  <= data_last;
                            state_q <= SEND;
                        end
                    end
                end
                default: begin
                    state_q <= RSTW;
                end
            endcase
        end
    end

    assign o0 = o0_q;
    assign o1 = o1_q;
    assign o2 = o2_q;
    assign o3 = o3_q;
    assign o4 = o4_q;

`ifdef NI_TX_FRMCNT_EN
    logic [15:0] frm_cnt_q;

    // Count frames on the acknowledgement of their EOF token; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frm_cnt_q <= '0;
        end else if ((state_q == SEND) && oa_s && (kind_q == K_EOF)) begin
            frm_cnt_q <= frm_cnt_q + 16'd1;
        end
    end

    assign frm_cnt = frm_cnt_q;
`endif

endmodule

// File: tb/tb_ni_tx_local.sv
// tb_ni_tx_local: frame table with token scoreboard, plus reset and
// back-pressure sequences for ni_tx_local.
module tb_ni_tx_local;

    localparam int DW   = 16;
    localparam int SCN  = 8;
    localparam int SYNC = 2;
    localparam int PER  = 2 * SYNC + 2;

    localparam logic [1:0] K_HEAD = 2'd0;
    localparam logic [1:0] K_BODY = 2'd1;
    localparam logic [1:0] K_EOF  = 2'd2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           hdr_valid;
    logic           hdr_ready;
    logic [3:0]     dst_x;
    logic [3:0]     dst_y;
    logic [DW-9:0]  hdr_usr;
    logic           data_valid;
    logic           data_ready;
    logic [DW-1:0]  data;
    logic           data_last;
    logic [SCN-1:0] o0;
    logic [SCN-1:0] o1;
    logic [SCN-1:0] o2;
    logic [SCN-1:0] o3;
    logic           o4;
    logic           oa;
`ifdef NI_TX_FRMCNT_EN
    logic [15:0]    frm_cnt;
`endif

    logic auto_ack;
    logic stall;
    logic oa_man;
    logic any_rail;

    always #5 clk = ~clk;

    assign any_rail = (|o0) | (|o1) | (|o2) | (|o3) | o4;
    assign oa = auto_ack ? (any_rail && !stall) : oa_man;

    ni_tx_local #(
        .DW   (DW),
        .SCN  (SCN),
        .SYNC (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hdr_valid  (hdr_valid),
        .hdr_ready  (hdr_ready),
        .dst_x      (dst_x),
        .dst_y      (dst_y),
        .hdr_usr    (hdr_usr),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data       (data),
        .data_last  (data_last),
        .o0         (o0),
        .o1         (o1),
        .o2         (o2),
        .o3         (o3),
        .o4         (o4),
`ifdef NI_TX_FRMCNT_EN
        .frm_cnt    (frm_cnt),
`endif
        .oa         (oa)
    );

    typedef struct packed {
        logic [3:0]  dx;
        logic [3:0]  dy;
        logic [7:0]  usr;
        logic [2:0]  n;
        logic [63:0] w;
        logic [3:0]  gap;
        logic [4:0]  stl;
        logic [7:0]  h0;
        logic [7:0]  h1;
        logic [7:0]  h2;
        logic [7:0]  h3;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } frame_t;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
        logic       r4;
    } tok_t;

    tok_t        exp_q[$];
    frame_t      tbl[4];
    int          checks;
    int          errors;
    int          cyc;
    int          tok_cnt;
    int          last_start;
    logic        prev_any;
    logic [32:0] prev_rails;
    logic        mon_en;
    logic        chk_period;

    function automatic logic [31:0] ref_enc(input logic [15:0] w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            int v;
            v = int'((w >> (2 * k)) & 16'h3);
            r[v * 8 + k] = 1'b1;
        end
        return r;
    endfunction

    task automatic push_tok(input logic [1:0] kind, input logic [31:0] r,
                            input logic r4);
        tok_t t;
        t.kind = kind;
        t.r0   = r[7:0];
        t.r1   = r[15:8];
        t.r2   = r[23:16];
        t.r3   = r[31:24];
        t.r4   = r4;
        exp_q.push_back(t);
    endtask

    task automatic monitor();
        logic [32:0] cur;
        logic        any;
        tok_t        e;
        cur = {o4, o3, o2, o1, o0};
        any = |cur;
        checks++;
        if ((hdr_ready && data_ready) || ((hdr_ready || data_ready) && any)) begin
            errors++;
            $display("FAIL ready_rule: hdr_ready=%0b data_ready=%0b rails=%h required exclusive and rails 0",
                     hdr_ready, data_ready, cur);
        end
        if (any && !prev_any) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_token: got %h required no token", cur);
            end else begin
                e = exp_q.pop_front();
                if (cur != {e.r4, e.r3, e.r2, e.r1, e.r0}) begin
                    errors++;
                    $display("FAIL token kind%0d: got %h required %h", e.kind, cur,
                             {e.r4, e.r3, e.r2, e.r1, e.r0});
                end
                tok_cnt++;
                if (chk_period && e.kind != K_HEAD) begin
                    checks++;
                    if (cyc - last_start != PER) begin
                        errors++;
                        $display("FAIL token_period: got %0d required %0d",
                                 cyc - last_start, PER);
                    end
                end
                last_start = cyc;
            end
        end else if (any && prev_any) begin
            checks++;
            if (cur != prev_rails) begin
                errors++;
                $display("FAIL token_hold: got %h required %h", cur, prev_rails);
            end
        end
        prev_any   = any;
        prev_rails = cur;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mon_en) monitor();
    endtask

    task automatic wait_ready(input logic is_data, output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (is_data ? data_ready : hdr_ready) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic send_frame(input frame_t f);
        logic ok;
        logic [15:0] w;
        tok_cnt    = 0;
        chk_period = (f.gap == 4'd0) && (f.stl == 5'd0);
        stall      = (f.stl != 5'd0);
        dst_x      = f.dx;
        dst_y      = f.dy;
        hdr_usr    = f.usr;
        hdr_valid  = 1'b1;
        wait_ready(1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hdr_timeout: got hdr_ready=0 required 1");
            hdr_valid = 1'b0;
            stall     = 1'b0;
            return;
        end
        push_tok(K_HEAD, {f.h3, f.h2, f.h1, f.h0}, 1'b0);
        tick();
        hdr_valid = 1'b0;
        if (f.stl != 5'd0) begin
            repeat (int'(f.stl)) tick();
            checks++;
            if ({o3, o2, o1, o0, o4} != {f.h3, f.h2, f.h1, f.h0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold: got %h required %h",
                         {o3, o2, o1, o0, o4}, {f.h3, f.h2, f.h1, f.h0, 1'b0});
            end
            stall = 1'b0;
        end
        for (int i = 0; i < int'(f.n); i++) begin
            if (f.gap != 4'd0) repeat (int'(f.gap)) tick();
            w          = f.w[16*i +: 16];
            data       = w;
            data_last  = (i == int'(f.n) - 1);
            data_valid = 1'b1;
            wait_ready(1'b1, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL data_timeout: got data_ready=0 required 1");
                data_valid = 1'b0;
                return;
            end
            push_tok(K_BODY, (i == 0) ? {f.b3, f.b2, f.b1, f.b0} : ref_enc(w), 1'b0);
            if (i == int'(f.n) - 1) push_tok(K_EOF, 32'h0, 1'b1);
            tick();
            data_valid = 1'b0;
        end
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick();
        wait_ready(1'b0, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_end: got pending=%0d idle=%0b required 0 and 1",
                     exp_q.size(), ok);
            exp_q.delete();
        end
        checks++;
        if (tok_cnt != int'(f.n) + 2) begin
            errors++;
            $display("FAIL token_count: got %0d required %0d", tok_cnt, int'(f.n) + 2);
        end
    endtask

    initial begin
        int n;
        logic ok;
        logic flag;

        tbl[0] = '{4'd5, 4'd10, 8'h00, 3'd1, 64'h0000_0000_0000_E4E4, 4'd0, 5'd0,
                   8'hF0, 8'h03, 8'h0C, 8'h00, 8'h11, 8'h22, 8'h44, 8'h88};
        tbl[1] = '{4'd0, 4'd0, 8'hFF, 3'd3, 64'h0000_1234_FFFF_0000, 4'd0, 5'd0,
                   8'h0F, 8'h00, 8'h00, 8'hF0, 8'hFF, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{4'hF, 4'h6, 8'h1B, 3'd2, 64'h0000_0000_AAAA_5555, 4'd3, 5'd15,
                   8'h80, 8'h48, 8'h24, 8'h13, 8'h00, 8'hFF, 8'h00, 8'h00};
        tbl[3] = '{4'h9, 4'h3, 8'hE4, 3'd4, 64'h0F0F_C3C3_2222_1B1B, 4'd0, 5'd0,
                   8'h18, 8'h21, 8'h42, 8'h84, 8'h88, 8'h44, 8'h22, 8'h11};

        checks     = 0;
        errors     = 0;
        cyc        = 0;
        tok_cnt    = 0;
        last_start = 0;
        prev_any   = 1'b0;
        prev_rails = '0;
        mon_en     = 1'b0;
        chk_period = 1'b0;
        rst_n      = 1'b0;
        auto_ack   = 1'b0;
        oa_man     = 1'b1;
        stall      = 1'b0;
        hdr_valid  = 1'b0;
        data_valid = 1'b0;
        dst_x      = '0;
        dst_y      = '0;
        hdr_usr    = '0;
        data       = '0;
        data_last  = 1'b0;

        repeat (10) tick();
        checks++;
        if (any_rail || hdr_ready || data_ready) begin
            errors++;
            $display("FAIL reset_state: rails=%0b hdr_ready=%0b data_ready=%0b required 0",
                     any_rail, hdr_ready, data_ready);
        end
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (hdr_ready || any_rail) begin
            errors++;
            $display("FAIL rstw_block: hdr_ready=%0b required 0 while ack held", hdr_ready);
        end
        oa_man = 1'b0;
        n = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            n++;
            if (hdr_ready) break;
        end
        checks++;
        if (n != SYNC + 1 || !hdr_ready) begin
            errors++;
            $display("FAIL rstw_release: got %0d cycles required %0d", n, SYNC + 1);
        end

        auto_ack = 1'b1;
        prev_any = 1'b0;
        mon_en   = 1'b1;
        for (int i = 0; i < 4; i++) send_frame(tbl[i]);
        mon_en = 1'b0;

`ifdef NI_TX_FRMCNT_EN
        checks++;
        if (frm_cnt != 16'd4) begin
            errors++;
            $display("FAIL frm_cnt: got %0d required 4", frm_cnt);
        end
        dut.frm_cnt_q = 16'hFFFF;
        prev_any = 1'b0;
        mon_en   = 1'b1;
        send_frame(tbl[0]);
        mon_en = 1'b0;
        checks++;
        if (frm_cnt != 16'd0) begin
            errors++;
            $display("FAIL frm_cnt_wrap: got %0d required 0", frm_cnt);
        end
`endif

        auto_ack  = 1'b0;
        oa_man    = 1'b0;
        dst_x     = tbl[0].dx;
        dst_y     = tbl[0].dy;
        hdr_usr   = tbl[0].usr;
        hdr_valid = 1'b1;
        wait_ready(1'b0, ok);
        tick();
        hdr_valid = 1'b0;
        oa_man    = 1'b1;
        for (int t = 0; t < 50 && any_rail; t++) tick();
        oa_man     = 1'b0;
        data       = 16'h1234;
        data_last  = 1'b0;
        data_valid = 1'b1;
        wait_ready(1'b1, ok);
        tick();
        data_valid = 1'b0;
        checks++;
        if ({o3, o2, o1, o0, o4} != {ref_enc(16'h1234), 1'b0}) begin
            errors++;
            $display("FAIL mid_body: got %h required %h",
                     {o3, o2, o1, o0, o4}, {ref_enc(16'h1234), 1'b0});
        end
        oa_man = 1'b1;
        rst_n  = 1'b0;
        tick();
        checks++;
        if (any_rail) begin
            errors++;
            $display("FAIL mid_reset: got rails=%h required 0", {o4, o3, o2, o1, o0});
        end
        tick();
        rst_n     = 1'b1;
        hdr_valid = 1'b1;
        flag      = 1'b0;
        repeat (8) begin
            tick();
            if (hdr_ready || any_rail) flag = 1'b1;
        end
        checks++;
        if (flag) begin
            errors++;
            $display("FAIL post_reset_block: got accept=1 required 0 while ack held");
        end
        oa_man = 1'b0;
        n = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            n++;
            if (hdr_ready) break;
        end
        checks++;
        if (n != SYNC + 1 || !hdr_ready) begin
            errors++;
            $display("FAIL post_reset_release: got %0d cycles required %0d", n, SYNC + 1);
        end
        tick();
        hdr_valid = 1'b0;
        checks++;
        if ({o3, o2, o1, o0, o4} != {tbl[0].h3, tbl[0].h2, tbl[0].h1, tbl[0].h0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_head: got %h required %h", {o3, o2, o1, o0, o4},
                     {tbl[0].h3, tbl[0].h2, tbl[0].h1, tbl[0].h0, 1'b0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
